dmem_load_tracker: RTL
======================

# dmem_load_tracker

Load-miss issue and tracking stage directly downstream of the data cache, between its miss/prefetch request path and the main memory bus. It buffers line-load requests, issues them as BUS_LOAD commands, and records the memory-assigned transaction tag for each accepted request. When memory returns data for a tag, it presents a registered fill (line address plus data) back to the cache. Requests for a line that is already queued or in flight are absorbed without issuing a second load.

## Interface
- REQ_DEPTH, 4: request queue entries (power of two, ≥2)
- NUM_TAGS, 16: memory tag space; tag 0 means "none", so 15 trackable transactions
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low; clears all state while low
- req_valid  in  1  cache presents a line-load request
- req_addr  in  64  byte address; bits [2:0] ignored
- req_ready  out  1  queue can accept (not full)
- proc2Dmem_command  out  2  BUS_NONE=0 / BUS_LOAD=1; this block never issues BUS_STORE
- proc2Dmem_addr  out  64  issued address, bits [2:0] forced to 0
- Dmem2proc_response  in  4  nonzero = request accepted with this tag; 0 = rejected
- Dmem2proc_tag  in  4  nonzero = Dmem2proc_data belongs to this tag
- Dmem2proc_data  in  64  returned line data
- fill_valid  out  1  fill strobe to cache (one cycle per fill)
- fill_addr  out  64  line address of fill, [2:0]=0
- fill_data  out  64  fill data
- outstanding_count  out  4  valid tag-table entries
- err_tag  out  1  sticky protocol-error flag

## Operation
- Request queue: circular FIFO of line addresses with head/tail pointers plus a count.
- Enqueue when req_valid & req_ready & no duplicate. A duplicate is a line address (bits [63:3]) equal to any valid queue entry or any valid tag-table entry, evaluated on registered state. Duplicates are accepted (handshake completes) but dropped.
- Issue: whenever the queue is non-empty, proc2Dmem_command=BUS_LOAD and proc2Dmem_addr=head, combinationally. Otherwise command=BUS_NONE and addr=0.
- Response sampling: if issuing and Dmem2proc_response≠0, pop the head and write table[response] = {valid=1, addr=head}. If response=0, the head holds and is reissued the next cycle.
- Return: if Dmem2proc_tag≠0 and table[tag].valid, then on the next edge clear the entry and register fill_valid=1, fill_addr=table addr, fill_data=Dmem2proc_data. Otherwise fill_valid=0.
- Errors set err_tag; it clears only on reset:
  - Dmem2proc_tag≠0 hitting an invalid entry. No fill is produced.
  - Response tag whose entry is already valid. The entry is overwritten.
- Same tag retired and re-granted in the same cycle: set wins; the entry ends valid with the new address, and the fill for the old address is still produced.
- Enqueue and pop in the same cycle: count unchanged. req_ready = count<REQ_DEPTH and does not anticipate a same-cycle pop.
- Reset low mid-operation: queue, table, and counters are cleared immediately and in-flight tags are forgotten. Later returns for those tags raise err_tag only if they arrive after reset is released.

## Timing
- Reset values: req_ready=1, proc2Dmem_command=BUS_NONE, proc2Dmem_addr=0, fill_valid=0, fill_addr=0, fill_data=0, outstanding_count=0, err_tag=0.
- Request-to-command latency: 1 cycle. An enqueue at edge N drives BUS_LOAD during cycle N+1.
- Issue throughput: one accepted load per cycle while memory keeps granting.
- Fill latency: 1 cycle after a valid Dmem2proc_tag.
- outstanding_count and the duplicate check reflect the post-edge state.

## Test plan
- Single load: req 0x1000 → cycle+1 BUS_LOAD with addr 0x1000. Response 3 → outstanding_count=1. Tag 3 with data 0xDEAD → next cycle fill_valid=1, fill_addr=0x1000, fill_data=0xDEAD, count=0.
- Rejection: response=0 for 3 cycles, then 5 → addr 0x2008 is held for 4 cycles, popped once, and table[5] is set.
- Full queue: 4 distinct requests with memory rejecting → req_ready=0. A 5th request is not accepted until one grant.
- Duplicate: req 0x3000 then 0x3004 (same line), and later 0x3000 again while in flight → exactly one BUS_LOAD issued.
- Tag reuse and errors: tag 7 returns and is re-granted in the same cycle → fill for the old address, and table[7] holds the new address. A return on tag 9 with nothing outstanding → err_tag=1 and no fill.
- Async reset with 3 outstanding: all outputs go to reset values with no clock edge. After release, the first new request issues normally.

Source files
------------

// File: rtl/dmem_load_tracker.sv
// Load-miss issue/tracking stage between the data cache and the memory bus:
// queues line loads, issues BUS_LOAD, tracks granted tags and returns fills.
module dmem_load_tracker #(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned NUM_TAGS  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [63:0]                  req_addr,
  output logic                         req_ready,
  output logic [1:0]                   proc2Dmem_command,
  output logic [63:0]                  proc2Dmem_addr,
  input  logic [$clog2(NUM_TAGS)-1:0]  Dmem2proc_response,
  input  logic [$clog2(NUM_TAGS)-1:0]  Dmem2proc_tag,
  input  logic [63:0]                  Dmem2proc_data,
  output logic                         fill_valid,
  output logic [63:0]                  fill_addr,
  output logic [63:0]                  fill_data,
  output logic [$clog2(NUM_TAGS)-1:0]  outstanding_count,
  output logic                         err_tag
);

  localparam int unsigned PTR_W  = $clog2(REQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TAG_W  = $clog2(NUM_TAGS);
  localparam int unsigned LINE_W = 61;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  logic [LINE_W-1:0] q_line [REQ_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic [NUM_TAGS-1:0] tbl_valid;
  logic [NUM_TAGS-1:0] tbl_valid_nxt;
  logic [LINE_W-1:0]   tbl_line [NUM_TAGS];

  logic [LINE_W-1:0] req_line;
  logic              issue;
  logic              grant;
  logic              ret_hit;
  logic              ret_miss;
  logic              grant_conflict;
  logic              dup;
  logic              push;
  logic [PTR_W-1:0]  q_off;
  logic              unused_addr_bits;

  assign req_line         = req_addr[63:3];
  assign unused_addr_bits = ^req_addr[2:0];

  assign issue     = (count != '0);
  assign req_ready = (count < CNT_W'(REQ_DEPTH));
  assign grant     = issue && (Dmem2proc_response != '0);
  assign ret_hit   = (Dmem2proc_tag != '0) && tbl_valid[Dmem2proc_tag];
  assign ret_miss  = (Dmem2proc_tag != '0) && !tbl_valid[Dmem2proc_tag];
  // Re-granting a tag that retires in the same cycle is legitimate reuse.
  assign grant_conflict = grant && tbl_valid[Dmem2proc_response] &&
                          !(ret_hit && (Dmem2proc_tag == Dmem2proc_response));

  assign proc2Dmem_command = issue ? BUS_LOAD : BUS_NONE;
  assign proc2Dmem_addr    = issue ? {q_line[head], 3'b000} : 64'd0;

  // Duplicate line check against occupied queue slots and in-flight tags.
  always_comb begin
    dup   = 1'b0;
    q_off = '0;
    for (int i = 0; i < REQ_DEPTH; i++) begin
      q_off = PTR_W'(i) - head;
      if (({1'b0, q_off} < count) && (q_line[i] == req_line)) dup = 1'b1;
    end
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (tbl_valid[t] && (tbl_line[t] == req_line)) dup = 1'b1;
    end
  end

  assign push = req_valid && req_ready && !dup;

  always_comb begin
    count_nxt = count;
    case ({push, grant})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Retire first, then grant, so a same-cycle reuse of a tag ends valid.
  always_comb begin
    tbl_valid_nxt = tbl_valid;
    if (ret_hit) tbl_valid_nxt[Dmem2proc_tag] = 1'b0;
    if (grant)   tbl_valid_nxt[Dmem2proc_response] = 1'b1;
  end

  always_comb begin
    outstanding_count = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      outstanding_count = outstanding_count + TAG_W'(tbl_valid[t]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      tbl_valid  <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      err_tag    <= 1'b0;
      for (int i = 0; i < REQ_DEPTH; i++) q_line[i] <= '0;
      for (int t = 0; t < NUM_TAGS; t++) tbl_line[t] <= '0;
    end else begin
      if (push) begin
        q_line[tail] <= req_line;
        tail         <= tail + PTR_W'(1);
      end
      if (grant) begin
        head                         <= head + PTR_W'(1);
        tbl_line[Dmem2proc_response] <= q_line[head];
      end
      count      <= count_nxt;
      tbl_valid  <= tbl_valid_nxt;
      fill_valid <= ret_hit;
      if (ret_hit) begin
        fill_addr <= {tbl_line[Dmem2proc_tag], 3'b000};
        fill_data <= Dmem2proc_data;
      end
      if (ret_miss || grant_conflict) err_tag <= 1'b1;
    end
  end

endmodule
